// File: rtl/dcs_requant_pkg.sv
// dcs_requant shared types, sizes and the round/saturate helper.
// Holds state encodings, widths and requant() for the EMIT datapath.
package dcs_pkg;

  localparam int N_WORDS = 8;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SHIFT   = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Round-half-up then saturate; the sum has one spare bit so the
  // rounding carry out of an all-ones word is kept.
  function automatic logic [OUT_W-1:0] requant(
    input logic [IN_W-1:0]    w,
    input logic [SHIFT_W-1:0] sh
  );
    logic [IN_W:0] rnd;
    logic [IN_W:0] sum;
    logic [IN_W:0] q;
    rnd = '0;
    if (sh != '0)
      rnd = {{IN_W{1'b0}}, 1'b1} << (sh - 1'b1);
    sum = {1'b0, w} + rnd;
    q   = sum >> sh;
    return (|q[IN_W:OUT_W]) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dcs_requant_if.sv
// dcs_requant stream bundle: word input side and byte output side.
// slave = requant stage view, master = producer/consumer view.
interface dcs_requant_if;
  import dcs_pkg::*;

  logic               in_valid;
  logic [IN_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
  logic [SHIFT_W-1:0] out_shift;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, out_shift
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, out_shift
  );

endinterface

// File: rtl/dcs_requant_lzd.sv
// dcs_lzd: combinational leading-one detector.
// din -> msb (index of highest set bit), zero (din == 0).
module dcs_lzd
  import dcs_pkg::*;
(
  input  logic [IN_W-1:0]    din,
  output logic [SHIFT_W-1:0] msb,
  output logic               zero
);

  always_comb begin
    msb = '0;
    for (int i = 0; i < IN_W; i++)
      if (din[i]) msb = SHIFT_W'(i);
  end

  assign zero = ~|din;

endmodule

// File: rtl/dcs_requant.sv
// dcs_requant: 8-word burst -> shared shift -> 8 rounded bytes.
// Ports: clk, rst_n (sync, active-high), bus (slave), ovf_err. Macro DCS_REQ_DBUF_EN adds a 2nd bank.
module dcs_requant
  import dcs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  dcs_requant_if.slave bus,
  output logic         ovf_err
);

  localparam logic [1:0] S_COL = COLLECT;
  localparam logic [1:0] S_SHF = SHIFT;
  localparam logic [1:0] S_EMT = EMIT;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_WORDS - 1);

  logic [1:0]         state;
  logic [IN_W-1:0]    buf_q [2][N_WORDS];
  logic [CNT_W-1:0]   cnt_q [2];
  logic [IN_W-1:0]    max_q [2];
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_c;
  logic [SHIFT_W-1:0] msb;
  logic [IDX_W-1:0]   e_idx;
  logic               wb;
  logic               rb;
  logic               zero;
  logic               wr;
  logic               wr_last;
  logic               cur_rdy;
  logic               nxt_rdy;
  logic               xfer_last;

  // A full bank refuses words; in the single-bank build the bank
  // stays full from its 8th word until its last byte leaves.
  assign wr      = bus.in_valid && (cnt_q[wb] != FULL);
  assign wr_last = wr && (cnt_q[wb] == FULL - 1'b1);
  assign cur_rdy = (cnt_q[rb] == FULL) || (wr_last && (wb == rb));

  assign xfer_last = (state == S_EMT) && bus.out_valid &&
                     bus.out_ready && bus.out_last;

`ifdef DCS_REQ_DBUF_EN
  assign nxt_rdy = (cnt_q[~rb] == FULL) || (wr_last && (wb == ~rb));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      if (wr_last)   wb <= ~wb;
      if (xfer_last) rb <= ~rb;
    end
  end
`else
  assign nxt_rdy = 1'b0;
  assign wb      = 1'b0;
  assign rb      = 1'b0;
`endif

  dcs_lzd u_lzd (
    .din  (max_q[rb]),
    .msb  (msb),
    .zero (zero)
  );

  assign shift_c = (!zero && (msb > 5'd7)) ? msb - 5'd7 : '0;

  always_ff @(posedge clk) begin
    if (wr) buf_q[wb][cnt_q[wb][IDX_W-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= S_COL;
      shift_q       <= '0;
      e_idx         <= '0;
      ovf_err       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_shift <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        max_q[b] <= '0;
      end
    end else begin
      if (bus.in_valid && !wr) ovf_err <= 1'b1;
      if (wr) begin
        cnt_q[wb] <= cnt_q[wb] + 1'b1;
        if (bus.in_data > max_q[wb]) max_q[wb] <= bus.in_data;
      end
      unique case (state)
        S_COL: begin
          if (cur_rdy) state <= S_SHF;
        end
        S_SHF: begin
          shift_q <= shift_c;
          e_idx   <= '0;
          state   <= S_EMT;
        end
        S_EMT: begin
          if (xfer_last) begin
            bus.out_valid <= 1'b0;
            cnt_q[rb]     <= '0;
            max_q[rb]     <= '0;
            state         <= nxt_rdy ? S_SHF : S_COL;
          end else if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= requant(buf_q[rb][e_idx], shift_q);
            bus.out_last  <= (e_idx == LAST);
            bus.out_shift <= shift_q;
            e_idx         <= e_idx + 1'b1;
          end
        end
        default: state <= S_COL;
      endcase
    end
  end

endmodule

// File: tb/tb_dcs_requant.sv
// tb_dcs_requant: randomized scoreboard bench for dcs_requant.
// Reference model works on whole vectors with integer arithmetic.
module tb_dcs_requant;
  import dcs_pkg::*;

  typedef logic [31:0] vec_t [8];
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [4:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ovf_err;
  dcs_requant_if bus ();

  dcs_requant dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int ready_mode = 0;
  int pat_i = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int ref_shift(input vec_t v);
    longint m = 0;
    int p = -1;
    foreach (v[i]) if (longint'(v[i]) > m) m = longint'(v[i]);
    for (longint t = m; t != 0; t = t / 2) p++;
    return (p > 7) ? p - 7 : 0;
  endfunction

  function automatic int ref_byte(input logic [31:0] w, input int sh);
    longint s = longint'(w);
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >> sh;
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic push_exp(input vec_t v);
    int sh = ref_shift(v);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.d = 8'(ref_byte(v[i], sh));
      e.l = (i == 7);
      e.s = 5'(sh);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input bit gaps);
    push_exp(v);
    for (int i = 0; i < 8; i++) begin
      send_word(v[i]);
      if (gaps && i < 7)
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_timeout", 32'(t < 300), 1);
  endtask

  task automatic rand_vec(output vec_t v);
    for (int i = 0; i < 8; i++) v[i] = $urandom >> $urandom_range(0, 31);
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin bus.out_ready = pat[pat_i % 4]; pat_i++; end
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every transfer, checks stalls
  initial begin
    bit stall = 0;
    logic [7:0] h_d;
    logic h_l;
    logic [4:0] h_s;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(bus.out_valid), 1);
          chk("stall_data", 32'(bus.out_data), 32'(h_d));
          chk("stall_last", 32'(bus.out_last), 32'(h_l));
          chk("stall_shift", 32'(bus.out_shift), 32'(h_s));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(bus.out_data), 32'(e.d));
            chk("last", 32'(bus.out_last), 32'(e.l));
            chk("shift", 32'(bus.out_shift), 32'(e.s));
          end
        end
        stall = bus.out_valid && !bus.out_ready;
        h_d = bus.out_data;
        h_l = bus.out_last;
        h_s = bus.out_shift;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t d;
    int t;
    bit exp_ovf;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_shift", 32'(bus.out_shift), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // 10..80: shift 0, exact latency, no bubbles
    ready_mode = 0;
    for (int i = 0; i < 8; i++) v[i] = 32'((i + 1) * 10);
    push_exp(v);
    for (int i = 0; i < 8; i++) send_word(v[i]);
    chk("lat_e0", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_e1", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_e2", 32'(bus.out_valid), 1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("no_bubble", 32'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    chk("valid_drop", 32'(bus.out_valid), 0);
    wait_drain();

    v = '{1000, 500, 3, 0, 255, 256, 999, 1};
    send_vec(v, 0);
    wait_drain();

    for (int i = 0; i < 8; i++) v[i] = 32'hFFFF_FFFF;
    send_vec(v, 0);
    wait_drain();

    ready_mode = 2;
    pat_i = 0;
    rand_vec(v);
    send_vec(v, 0);
    wait_drain();

    ready_mode = 1;
    for (int n = 0; n < 6; n++) begin
      rand_vec(v);
      send_vec(v, 1);
      wait_drain();
    end
    chk("ovf_clean", 32'(ovf_err), 0);

    // words arriving during EMIT
    ready_mode = 3;
    rand_vec(v);
    send_vec(v, 0);
    t = 0;
    while (!bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("emit_wait", 32'(bus.out_valid), 1);
    rand_vec(d);
    for (int i = 0; i < 3; i++) send_word(d[i]);
`ifdef DCS_REQ_DBUF_EN
    exp_ovf = 0;
`else
    exp_ovf = 1;
`endif
    chk("ovf_set", 32'(ovf_err), 32'(exp_ovf));
    ready_mode = 0;
    wait_drain();
`ifdef DCS_REQ_DBUF_EN
    push_exp(d);
    for (int i = 3; i < 8; i++) send_word(d[i]);
`else
    send_vec(d, 1);
`endif
    wait_drain();
    chk("ovf_sticky", 32'(ovf_err), 32'(exp_ovf));

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) send_word(32'h00FF_0000 + 32'(i));
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    chk("mid_rst_shift", 32'(bus.out_shift), 0);
    chk("mid_rst_ovf", 32'(ovf_err), 0);
    v = '{7, 1, 2, 3, 4, 5, 6, 200};
    send_vec(v, 0);
    wait_drain();
    chk("final_ovf", 32'(ovf_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcs_requant.md
Name: dcs_requant

Overview:
- Downstream stage of the DCSformer attention core.
- Collects each 8-word burst of 32-bit unsigned results (o_valid/o_data), finds the burst maximum and derives one shared right-shift.
- Requantizes all 8 words to 8-bit unsigned with round-half-up and saturation.
- Emits the bytes on a valid/ready stream to the next layer's input loader.

Parameters:
- N_WORDS, 8, words per burst/vector
- IN_W, 32, input word width (unsigned)
- OUT_W, 8, output byte width (unsigned)

Ports:
- clk  input  1  single clock
- rst_n  input  1  reset; synchronous, active-high (asserted = 1), despite the name
- in_valid  input  1  input word strobe; no backpressure toward upstream
- in_data  input  IN_W  result word, unsigned
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accept
- out_data  output  OUT_W  requantized byte
- out_last  output  1  high with the 8th byte of a vector
- out_shift  output  5  shift applied to the current vector; valid with out_valid
- ovf_err  output  1  sticky; set when an input word is dropped

Behaviour:
- Reset: applies on a clk edge with rst_n=1, including mid-operation.
  - out_valid, out_data, out_last, out_shift, ovf_err = 0.
  - State = COLLECT; word count = 0; running max = 0.
  - Any partial vector is discarded.
- States: COLLECT -> SHIFT -> EMIT -> COLLECT.
- COLLECT:
  - Each in_valid writes in_data to buf[cnt], increments cnt and updates the running max.
  - The word that makes cnt = N_WORDS moves the state to SHIFT.
  - in_valid need not be contiguous; gaps are allowed.
- SHIFT (1 cycle):
  - p = index of the most-significant set bit of max.
  - shift = p-7 if p>7, else 0.
  - If max = 0, shift = 0.
  - Shift is registered; state moves to EMIT.
- Latency: if the last word is sampled at edge E, out_valid first rises after edge E+2.
- EMIT:
  - byte k = sat255((buf[k] + (shift>0 ? 1<<(shift-1) : 0)) >> shift).
  - Compute the sum in IN_W+1 bits; no wrap.
  - out_data, out_last and out_shift hold stable while out_valid=1 and out_ready=0.
  - A transfer occurs on out_valid & out_ready; the next byte is presented the following cycle. There are no bubbles when out_ready is held high.
  - out_last = 1 for k = N_WORDS-1.
  - After the last transfer: out_valid = 0 next cycle, state = COLLECT, running max cleared.
- Words arriving with in_valid=1 while not in COLLECT (base build):
  - The word is dropped and ovf_err is set.
  - This includes the cycle of the last out transfer.
- ovf_err clears only on reset.

Optional Feature:
- Macro DCS_REQ_DBUF_EN.
- Defined:
  - Two buffer banks, each with its own count and max.
  - Collection into the alternate bank continues during SHIFT/EMIT of the other bank.
  - The next vector's SHIFT starts the cycle after the current vector's last transfer, if that bank is full.
  - ovf_err is set only when both banks are full/busy and in_valid=1.
- Undefined: single bank, drop behaviour as above.

Decomposition:
- Package dcs_pkg:
  - state enum {COLLECT, SHIFT, EMIT}
  - N_WORDS, IN_W, OUT_W
  - SHIFT_W=5 constant
  - sat/round helper function
- One sub-module dcs_lzd: combinational leading-one detector, IN_W -> 5-bit msb index plus zero flag. Used in SHIFT.

Test Plan:
- Words 10,20,...,80, out_ready=1:
  - max 80 -> shift 0.
  - Bytes 10..80 unchanged.
  - out_last on 80.
  - First out_valid exactly 2 cycles after the last input edge.
- Words {1000,500,3,0,255,256,999,1}:
  - p=9 -> shift 2.
  - Bytes {250,125,1,0,64,64,250,0}.
  - out_shift=2.
- Max 0xFFFFFFFF with all 8 words equal:
  - shift 24; rounding carries.
  - Bytes saturate to 255, no wrap.
- out_ready toggled 1,0,0,1 during EMIT: data/last stable while stalled; 8 transfers total, in order.
- Base build, 3 in_valid during EMIT:
  - Words dropped; ovf_err=1 and stays set.
  - The next full vector is still processed correctly.
  - With DCS_REQ_DBUF_EN: the same words are captured and ovf_err stays 0.
- Reset asserted after 5 words: outputs 0; a new full burst of 8 yields a correct vector with no residue from the partial one.
